// File: rtl/vmem_pkg.sv
// -----------------------------------------------------------------------------
// vmem_pkg
// Shared definitions for the vector load/store sequencer: the lane count,
// the sequencer state enumeration and the legal vector-size check.
// -----------------------------------------------------------------------------
package vmem_pkg;

   localparam int NLANES = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STORE = 2'd1,
      ST_LOAD  = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // A vector moves between 1 and NLANES lanes; anything else is rejected.
   function automatic logic vsize_legal(input logic [2:0] v);
      return (v != 3'd0) && (v <= 3'(NLANES));
   endfunction

endpackage

// File: rtl/vmem_lane_buf.sv
// -----------------------------------------------------------------------------
// vmem_lane_buf
// NLANES x DW lane buffer used by the vector sequencer.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (clears all lanes)
//   i_cap        - parallel load of all lanes from i_cap_data (store snapshot)
//   i_cap_data   - all lanes, lane 0 in the least significant slot
//   i_wr         - single-lane write of i_wr_data at i_idx (load beat)
//   i_idx        - lane index shared by the single-lane write and read
//   o_rd_data    - lane at i_idx (store data for the current beat)
//   o_lanes      - all lanes in parallel (register file write data)
// -----------------------------------------------------------------------------
module vmem_lane_buf
   import vmem_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_cap,
   input  logic [NLANES-1:0][DW-1:0]    i_cap_data,
   input  logic                         i_wr,
   input  logic [2:0]                   i_idx,
   input  logic [DW-1:0]                i_wr_data,
   output logic [DW-1:0]                o_rd_data,
   output logic [NLANES-1:0][DW-1:0]    o_lanes
);

   logic [NLANES-1:0][DW-1:0] r_lane;
   logic                      w_idx_ok;

   assign w_idx_ok = (i_idx < 3'(NLANES));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lane <= '0;
      end else if (i_cap) begin
         r_lane <= i_cap_data;
      end else if (i_wr && w_idx_ok) begin
         r_lane[i_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = w_idx_ok ? r_lane[i_idx] : '0;
   assign o_lanes   = r_lane;

endmodule

// File: rtl/vmem_seq.sv
// -----------------------------------------------------------------------------
// vmem_seq
// Vector load/store sequencer between the 5-lane vector register file and a
// single-word memory port. A store snapshots the register lanes in one cycle
// and serializes them to memory; a load gathers words one beat at a time and
// writes them back as a single all-lane register write.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start/is_store/vsize/
//   base_addr/vreg             - command, sampled only while idle
//   busy, done, err            - status; done/err are one-cycle pulses
//   mem_req/mem_ready/mem_we/
//   mem_addr/mem_wd/mem_rd     - memory beat interface (ready-qualified)
//   vrf_ra, vrf_rd1..5         - register file read (combinational in idle)
//   vrf_we/vrf_wa/vrf_wd1..5   - register file vector write
//   vrf_vector_op/size         - register file vector qualifier and lane count
// -----------------------------------------------------------------------------
module vmem_seq
   import vmem_pkg::*;
#(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int RAW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            is_store,
   input  logic [2:0]      vsize,
   input  logic [AW-1:0]   base_addr,
   input  logic [RAW-1:0]  vreg,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            mem_req,
   input  logic            mem_ready,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wd,
   input  logic [DW-1:0]   mem_rd,
   output logic [RAW-1:0]  vrf_ra,
   input  logic [DW-1:0]   vrf_rd1,
   input  logic [DW-1:0]   vrf_rd2,
   input  logic [DW-1:0]   vrf_rd3,
   input  logic [DW-1:0]   vrf_rd4,
   input  logic [DW-1:0]   vrf_rd5,
   output logic            vrf_we,
   output logic [RAW-1:0]  vrf_wa,
   output logic [DW-1:0]   vrf_wd1,
   output logic [DW-1:0]   vrf_wd2,
   output logic [DW-1:0]   vrf_wd3,
   output logic [DW-1:0]   vrf_wd4,
   output logic [DW-1:0]   vrf_wd5,
   output logic            vrf_vector_op,
   output logic [2:0]      vrf_vector_size
);

   state_t                    r_state;
   logic [2:0]                r_i;
   logic [2:0]                r_vsize;
   logic [RAW-1:0]            r_vreg;
   logic [AW-1:0]             r_addr;
   logic                      r_mem_req;
   logic                      r_mem_we;
   logic                      r_done;
   logic                      r_err;
   logic                      r_vrf_we;

   logic                      w_idle;
   logic                      w_legal;
   logic                      w_cap;
   logic                      w_ld_wr;
   logic                      w_last;
   logic [NLANES-1:0][DW-1:0] w_cap_data;
   logic [NLANES-1:0][DW-1:0] w_lanes;
   logic [DW-1:0]             w_rd_data;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_legal    = vsize_legal(vsize);
   assign w_cap      = w_idle && start && is_store && w_legal;
   assign w_ld_wr    = (r_state == ST_LOAD) && mem_ready;
   assign w_last     = (r_i == (r_vsize - 3'd1));
   assign w_cap_data = {vrf_rd5, vrf_rd4, vrf_rd3, vrf_rd2, vrf_rd1};

   vmem_lane_buf #(.DW(DW)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .i_cap      (w_cap),
      .i_cap_data (w_cap_data),
      .i_wr       (w_ld_wr),
      .i_idx      (r_i),
      .i_wr_data  (mem_rd),
      .o_rd_data  (w_rd_data),
      .o_lanes    (w_lanes)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_i       <= '0;
         r_vsize   <= '0;
         r_vreg    <= '0;
         r_addr    <= '0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_vrf_we  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (w_legal) begin
                     r_vsize   <= vsize;
                     r_vreg    <= vreg;
                     // Beats are word-granular: drop the byte offset.
                     r_addr    <= base_addr & ~AW'(3);
                     r_i       <= '0;
                     r_mem_req <= 1'b1;
                     r_mem_we  <= is_store;
                     r_state   <= is_store ? ST_STORE : ST_LOAD;
                  end else begin
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= ST_FIN;
                  end
               end
            end
            ST_STORE, ST_LOAD: begin
               if (mem_ready) begin
                  r_i    <= r_i + 3'd1;
                  r_addr <= r_addr + AW'(4);
                  if (w_last) begin
                     r_mem_req <= 1'b0;
                     r_mem_we  <= 1'b0;
                     r_done    <= 1'b1;
                     // Only a load hands its gathered lanes to the register file.
                     r_vrf_we  <= (r_state == ST_LOAD);
                     r_state   <= ST_FIN;
                  end
               end
            end
            default: begin
               r_done   <= 1'b0;
               r_err    <= 1'b0;
               r_vrf_we <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = !w_idle;
   assign done     = r_done;
   assign err      = r_err;
   assign mem_req  = r_mem_req;
   assign mem_we   = r_mem_we;
   assign mem_addr = r_addr;
   assign mem_wd   = w_rd_data;

   // While idle the read port follows the command so the snapshot is ready at
   // the accepting edge; afterwards it tracks the latched register.
   assign vrf_ra          = w_idle ? vreg : r_vreg;
   assign vrf_vector_op   = w_idle ? (start & is_store) : r_vrf_we;
   assign vrf_vector_size = w_idle ? vsize : r_vsize;

   assign vrf_we  = r_vrf_we;
   assign vrf_wa  = r_vreg;
   assign vrf_wd1 = w_lanes[0];
   assign vrf_wd2 = w_lanes[1];
   assign vrf_wd3 = w_lanes[2];
   assign vrf_wd4 = w_lanes[3];
   assign vrf_wd5 = w_lanes[4];

endmodule

// File: tb/tb_vmem_seq.sv
// -----------------------------------------------------------------------------
// tb_vmem_seq
// Scoreboard bench for vmem_seq: commands push expected memory writes and
// completions into queues; a monitor on the falling edge pops and compares.
// Memory and register file are behavioural arrays owned by the bench.
// -----------------------------------------------------------------------------
module tb_vmem_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, is_store;
   logic [2:0]  vsize;
   logic [31:0] base_addr;
   logic [3:0]  vreg;
   logic        busy, done, err;
   logic        mem_req, mem_ready, mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic [3:0]  vrf_ra, vrf_wa;
   logic [31:0] vrf_rd1, vrf_rd2, vrf_rd3, vrf_rd4, vrf_rd5;
   logic        vrf_we, vrf_vector_op;
   logic [31:0] vrf_wd1, vrf_wd2, vrf_wd3, vrf_wd4, vrf_wd5;
   logic [2:0]  vrf_vector_size;

   vmem_seq dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store),
      .vsize(vsize), .base_addr(base_addr), .vreg(vreg),
      .busy(busy), .done(done), .err(err),
      .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .vrf_ra(vrf_ra), .vrf_rd1(vrf_rd1), .vrf_rd2(vrf_rd2), .vrf_rd3(vrf_rd3),
      .vrf_rd4(vrf_rd4), .vrf_rd5(vrf_rd5),
      .vrf_we(vrf_we), .vrf_wa(vrf_wa), .vrf_wd1(vrf_wd1), .vrf_wd2(vrf_wd2),
      .vrf_wd3(vrf_wd3), .vrf_wd4(vrf_wd4), .vrf_wd5(vrf_wd5),
      .vrf_vector_op(vrf_vector_op), .vrf_vector_size(vrf_vector_size)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
   typedef struct {
      logic             err;
      logic             ld;
      logic [3:0]       vreg;
      logic [2:0]       sz;
      logic [4:0][31:0] lanes;
      int               start_cyc;
      int               exp_req;
   } done_t;

   wr_t         wq[$];
   done_t       dq[$];
   logic [31:0] memm [logic [31:0]];
   logic [31:0] vrf_m [16][5];

   int rmode      = 0;   // 0: always ready, 1: random, 2: scripted stalls
   int stall_left = 0;
   int req_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] memread(input logic [31:0] a);
      if (memm.exists(a)) return memm[a];
      return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
   endfunction

   // Memory side: ready pattern and read data, driven just after each edge.
   always @(posedge clk) begin
      #1;
      if (rmode == 0) mem_ready = 1'b1;
      else if (rmode == 1) mem_ready = ($urandom_range(0, 3) != 0);
      else if (mem_req && stall_left > 0) begin
         mem_ready = 1'b0;
         stall_left--;
      end else mem_ready = 1'b1;
      mem_rd = memread(mem_addr);
   end

   // Monitor / scoreboard.
   logic        have_hold = 1'b0;
   logic [31:0] hold_addr, hold_wd;
   logic        hold_we;
   always @(negedge clk) begin
      if (reset) begin
         req_cycles = 0;
         have_hold  = 1'b0;
      end else begin
         if (have_hold && mem_req) begin
            chk("hold_addr", mem_addr, hold_addr);
            if (hold_we) chk("hold_wd", mem_wd, hold_wd);
         end
         have_hold = mem_req && !mem_ready;
         hold_addr = mem_addr;
         hold_wd   = mem_wd;
         hold_we   = mem_we;
         if (mem_req) req_cycles++;
         if (mem_req && mem_ready && mem_we) begin
            if (wq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_store: addr %h data %h", mem_addr, mem_wd);
            end else begin
               wr_t w;
               w = wq.pop_front();
               chk("store_addr", mem_addr, w.a);
               chk("store_data", mem_wd, w.d);
            end
            memm[mem_addr] = mem_wd;
         end
         if (done) begin
            if (dq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_done: err %b vrf_we %b", err, vrf_we);
            end else begin
               done_t r;
               logic [4:0][31:0] got;
               r = dq.pop_front();
               got = {vrf_wd5, vrf_wd4, vrf_wd3, vrf_wd2, vrf_wd1};
               chk("done_err", 32'(err), 32'(r.err));
               chk("done_vrf_we", 32'(vrf_we), 32'(r.ld && !r.err));
               if (r.ld && !r.err) begin
                  chk("load_wa", 32'(vrf_wa), 32'(r.vreg));
                  chk("load_vsize", 32'(vrf_vector_size), 32'(r.sz));
                  chk("load_vop", 32'(vrf_vector_op), 32'd1);
                  for (int k = 0; k < 5; k++)
                     if (k < int'(r.sz)) begin
                        chk($sformatf("load_wd%0d", k + 1), got[k], r.lanes[k]);
                        vrf_m[r.vreg][k] = r.lanes[k];
                     end
               end
               if (r.exp_req >= 0) chk("req_cycles", 32'(req_cycles), 32'(r.exp_req));
               chk("done_latency", 32'(cyc - r.start_cyc), 32'(req_cycles + 1));
            end
            req_cycles = 0;
         end else if (vrf_we || err) begin
            tests++; fails++;
            $display("FAIL stray_pulse: vrf_we %b err %b without done", vrf_we, err);
         end
      end
   end

   task automatic set_rd(input logic [3:0] vr);
      vrf_rd1 = vrf_m[vr][0]; vrf_rd2 = vrf_m[vr][1]; vrf_rd3 = vrf_m[vr][2];
      vrf_rd4 = vrf_m[vr][3]; vrf_rd5 = vrf_m[vr][4];
   endtask

   // Issue one command at a post-edge point while idle, then wait for it to finish.
   task automatic issue(input logic st, input logic [2:0] sz, input logic [31:0] base,
                        input logic [3:0] vr);
      done_t       r;
      logic        legal;
      logic [31:0] al;
      legal = (sz >= 3'd1) && (sz <= 3'd5);
      al    = {base[31:2], 2'b00};
      for (int k = 0; k < 50 && busy; k++) begin @(posedge clk); #1; end
      set_rd(vr);
      r.err = !legal; r.ld = !st; r.vreg = vr; r.sz = sz; r.lanes = '0;
      r.start_cyc = cyc;
      if (!legal)          r.exp_req = 0;
      else if (rmode == 0) r.exp_req = int'(sz);
      else if (rmode == 2) r.exp_req = int'(sz) + stall_left;
      else                 r.exp_req = -1;
      for (int k = 0; k < 5; k++) begin
         if (legal && k < int'(sz)) begin
            if (st) wq.push_back('{a: al + 32'(4 * k), d: vrf_m[vr][k]});
            else    r.lanes[k] = memread(al + 32'(4 * k));
         end
      end
      dq.push_back(r);
      start = 1'b1; is_store = st; vsize = sz; base_addr = base; vreg = vr;
      #1;
      chk("idle_vrf_ra", 32'(vrf_ra), 32'(vr));
      chk("idle_vector_op", 32'(vrf_vector_op), 32'(st));
      chk("idle_vector_size", 32'(vrf_vector_size), 32'(sz));
      @(posedge clk); #1;
      // Command inputs and register read data are only meaningful in the start cycle.
      start = 1'b0; is_store = 1'($urandom); vsize = 3'($urandom);
      base_addr = $urandom; vreg = 4'($urandom);
      vrf_rd1 = $urandom; vrf_rd2 = $urandom; vrf_rd3 = $urandom;
      vrf_rd4 = $urandom; vrf_rd5 = $urandom;
      for (int k = 0; k < 400 && dq.size() != 0; k++) @(posedge clk);
      if (dq.size() != 0) begin
         tests++; fails++;
         $display("FAIL op_timeout: %0d completions outstanding", dq.size());
         dq.delete(); wq.delete();
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; is_store = 1'b0; vsize = '0; base_addr = '0; vreg = '0;
      mem_ready = 1'b0; mem_rd = '0;
      for (int v = 0; v < 16; v++) for (int k = 0; k < 5; k++) vrf_m[v][k] = $urandom;
      set_rd(4'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_vrf_we", 32'(vrf_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wd", mem_wd, 0);
      chk("rst_vrf_wd", vrf_wd1 | vrf_wd2 | vrf_wd3 | vrf_wd4 | vrf_wd5, 0);
      @(posedge clk); #1 reset = 1'b0;

      // Directed cases.
      rmode = 0;
      for (int k = 0; k < 5; k++) vrf_m[3][k] = 32'hA0 + 32'(k);
      issue(1'b1, 3'd5, 32'h100, 4'd3);
      memm[32'h200] = 32'd1; memm[32'h204] = 32'd2; memm[32'h208] = 32'd3;
      issue(1'b0, 3'd3, 32'h200, 4'd7);
      rmode = 2; stall_left = 2;
      issue(1'b0, 3'd2, 32'h200, 4'd4);
      rmode = 0;
      issue(1'b1, 3'd0, 32'h300, 4'd1);
      issue(1'b0, 3'd6, 32'h300, 4'd1);
      issue(1'b1, 3'd2, 32'hFFFF_FFFC, 4'd5);
      issue(1'b1, 3'd1, 32'h103, 4'd6);

      // Reset while the third beat of a 5-lane load is on the port.
      start = 1'b1; is_store = 1'b0; vsize = 3'd5; base_addr = 32'h400; vreg = 4'd2;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_mem_addr", mem_addr, 32'h408);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("abort_mem_req", 32'(mem_req), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_vrf_we", 32'(vrf_we), 0);
      repeat (4) @(posedge clk);
      #1;
      issue(1'b0, 3'd4, 32'h200, 4'd9);

      // Randomized commands with random memory back-pressure.
      rmode = 1;
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  sz;
         logic [31:0] b;
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 8) & 7) : 3'($urandom_range(1, 5));
         b  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : (32'h1000 + 32'($urandom_range(0, 255)));
         issue(1'($urandom), sz, b, 4'($urandom));
      end
      // Read back a stored vector through a load to close the loop.
      rmode = 0;
      issue(1'b1, 3'd5, 32'h800, 4'd11);
      issue(1'b0, 3'd5, 32'h800, 4'd12);

      chk("wq_drained", 32'(wq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
